// File: rtl/fsic_io_serdes_tx_arb.sv
// rtl/fsic_io_serdes_tx_arb.sv - round-robin arbiter feeding the IO serdes TX stream
// Optional packet lock: FSIC_TX_ARB_PKT_LOCK_EN (undefined = beat-level round-robin)
module fsic_io_serdes_tx_arb #(
    parameter int pN_REQ      = 3,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                            axis_clk,
    input  logic                            axis_rst,
    input  logic                            arb_en,
    input  logic [pN_REQ*pDATA_WIDTH-1:0]   s_tdata,
    input  logic [pN_REQ*pDATA_WIDTH/8-1:0] s_tstrb,
    input  logic [pN_REQ*pDATA_WIDTH/8-1:0] s_tkeep,
    input  logic [2*pN_REQ-1:0]             s_tuser,
    input  logic [pN_REQ-1:0]               s_tlast,
    input  logic [pN_REQ-1:0]               s_tvalid,
    output logic [pN_REQ-1:0]               s_tready,
    output logic [pDATA_WIDTH-1:0]          as_is_tdata,
    output logic [pDATA_WIDTH/8-1:0]        as_is_tstrb,
    output logic [pDATA_WIDTH/8-1:0]        as_is_tkeep,
    output logic [1:0]                      as_is_tid,
    output logic [1:0]                      as_is_tuser,
    output logic                            as_is_tlast,
    output logic                            as_is_tvalid,
    input  logic                            is_as_tready,
    output logic                            grant_vld,
    output logic [1:0]                      grant_id
);
    localparam int SW = pDATA_WIDTH / 8;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             owner_q, owner_d;
    logic [1:0]             last_q, last_d;
    logic [pDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [SW-1:0]          tstrb_q, tstrb_d;
    logic [SW-1:0]          tkeep_q, tkeep_d;
    logic [1:0]             tid_q, tid_d;
    logic [1:0]             tuser_q, tuser_d;
    logic                   tlast_q, tlast_d;
    logic                   tvalid_q, tvalid_d;

    // Requester lanes padded to four so a 2-bit index is always in range
    logic [3:0]             vld_pad;
    logic [3:0]             last_pad;
    logic [pDATA_WIDTH-1:0] data_arr [4];
    logic [SW-1:0]          strb_arr [4];
    logic [SW-1:0]          keep_arr [4];
    logic [1:0]             user_arr [4];

    for (genvar k = 0; k < 4; k++) begin : g_pad
        if (k < pN_REQ) begin : g_real
            assign vld_pad[k]  = s_tvalid[k];
            assign last_pad[k] = s_tlast[k];
            assign data_arr[k] = s_tdata[k*pDATA_WIDTH +: pDATA_WIDTH];
            assign strb_arr[k] = s_tstrb[k*SW +: SW];
            assign keep_arr[k] = s_tkeep[k*SW +: SW];
            assign user_arr[k] = s_tuser[k*2 +: 2];
        end else begin : g_none
            assign vld_pad[k]  = 1'b0;
            assign last_pad[k] = 1'b0;
            assign data_arr[k] = '0;
            assign strb_arr[k] = '0;
            assign keep_arr[k] = '0;
            assign user_arr[k] = '0;
        end
    end

    logic load;
    logic accept;
    assign load   = !tvalid_q || is_as_tready;
    assign accept = (state_q == ST_LOCKED) && vld_pad[owner_q] && load;

    // Search downward so the requester closest after last_q overrides the rest
    logic [2:0] cand;
    logic       sel_vld;
    logic [1:0] sel_idx;
    always_comb begin
        cand    = '0;
        sel_vld = 1'b0;
        sel_idx = last_q;
        for (int i = pN_REQ; i >= 1; i--) begin
            cand = {1'b0, last_q} + 3'(i);
            if (cand >= 3'(pN_REQ)) begin
                cand = cand - 3'(pN_REQ);
            end
            if (vld_pad[cand[1:0]]) begin
                sel_vld = 1'b1;
                sel_idx = cand[1:0];
            end
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            last_q   <= 2'(pN_REQ - 1);
            tdata_q  <= '0;
            tstrb_q  <= '0;
            tkeep_q  <= '0;
            tid_q    <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            tdata_q  <= tdata_d;
            tstrb_q  <= tstrb_d;
            tkeep_q  <= tkeep_d;
            tid_q    <= tid_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        tdata_d  = tdata_q;
        tstrb_d  = tstrb_q;
        tkeep_d  = tkeep_q;
        tid_d    = tid_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_en && sel_vld) begin
                    owner_d = sel_idx;
                    last_d  = sel_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
`ifdef FSIC_TX_ARB_PKT_LOCK_EN
                if (accept && last_pad[owner_q]) begin
                    state_d = ST_IDLE;
                end
`else
                if (accept) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            tvalid_d = accept;
        end
        if (accept) begin
            tdata_d = data_arr[owner_q];
            tstrb_d = strb_arr[owner_q];
            tkeep_d = keep_arr[owner_q];
            tuser_d = user_arr[owner_q];
            tlast_d = last_pad[owner_q];
            tid_d   = owner_q;
        end
    end

    logic [3:0] rdy_pad;
    always_comb begin
        rdy_pad = '0;
        if (state_q == ST_LOCKED) begin
            rdy_pad[owner_q] = load;
        end
    end

    assign s_tready     = rdy_pad[pN_REQ-1:0];
    assign grant_vld    = (state_q == ST_LOCKED);
    assign grant_id     = owner_q;
    assign as_is_tdata  = tdata_q;
    assign as_is_tstrb  = tstrb_q;
    assign as_is_tkeep  = tkeep_q;
    assign as_is_tid    = tid_q;
    assign as_is_tuser  = tuser_q;
    assign as_is_tlast  = tlast_q;
    assign as_is_tvalid = tvalid_q;

endmodule

// File: tb/tb_fsic_io_serdes_tx_arb.sv
// tb/tb_fsic_io_serdes_tx_arb.sv - randomized self-checking bench for fsic_io_serdes_tx_arb
module tb_fsic_io_serdes_tx_arb;
    localparam int N = 3;
    localparam int W = 32;
    localparam int S = W / 8;
`ifdef FSIC_TX_ARB_PKT_LOCK_EN
    localparam bit PKT = 1'b1;
`else
    localparam bit PKT = 1'b0;
`endif

    logic            axis_clk = 1'b0;
    logic            axis_rst = 1'b1;
    logic            arb_en = 1'b0;
    logic [N*W-1:0]  s_tdata = '0;
    logic [N*S-1:0]  s_tstrb = '0;
    logic [N*S-1:0]  s_tkeep = '0;
    logic [2*N-1:0]  s_tuser = '0;
    logic [N-1:0]    s_tlast = '0;
    logic [N-1:0]    s_tvalid = '0;
    logic [N-1:0]    s_tready;
    logic [W-1:0]    as_is_tdata;
    logic [S-1:0]    as_is_tstrb;
    logic [S-1:0]    as_is_tkeep;
    logic [1:0]      as_is_tid;
    logic [1:0]      as_is_tuser;
    logic            as_is_tlast;
    logic            as_is_tvalid;
    logic            is_as_tready = 1'b0;
    logic            grant_vld;
    logic [1:0]      grant_id;

    fsic_io_serdes_tx_arb #(.pN_REQ(N), .pDATA_WIDTH(W)) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst), .arb_en(arb_en),
        .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
        .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .as_is_tdata(as_is_tdata), .as_is_tstrb(as_is_tstrb), .as_is_tkeep(as_is_tkeep),
        .as_is_tid(as_is_tid), .as_is_tuser(as_is_tuser), .as_is_tlast(as_is_tlast),
        .as_is_tvalid(as_is_tvalid), .is_as_tready(is_as_tready),
        .grant_vld(grant_vld), .grant_id(grant_id)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic [S-1:0] strb;
        logic [S-1:0] keep;
        logic [1:0]   user;
        logic         last;
    } beat_t;

    beat_t drv_q [N][$];
    beat_t exp_q [N][$];
    int    pend_len [N][$];
    int    tid_q [$];
    int    model_last;
    int    checks = 0;
    int    failures = 0;
    int    ready_mode = 0;
    int    cyc = 0;
    int    hs_cnt [N];
    bit    arb_en_cmd = 1'b0;
    bit    timing_en = 1'b0;
    bit    first_pending = 1'b0;
    int    first_exp = 0;
    int    last_out_cyc = 0;
    bit    prev_out_last = 1'b0;
    bit    stall_prev = 1'b0;
    logic [63:0] held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int r, input int len, input logic [W-1:0] base, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = rnd ? W'($urandom) : base + W'(i);
            b.strb = S'($urandom);
            b.keep = S'($urandom);
            b.user = 2'($urandom);
            b.last = (i == len - 1);
            drv_q[r].push_back(b);
            exp_q[r].push_back(b);
        end
        pend_len[r].push_back(len);
    endtask

    // Round-robin from the last winner: whole packets when locked, single beats otherwise
    task automatic plan();
        int r;
        bit found;
        forever begin
            found = 1'b0;
            r = 0;
            for (int i = 1; i <= N; i++) begin
                if (!found && pend_len[(model_last + i) % N].size() > 0) begin
                    found = 1'b1;
                    r = (model_last + i) % N;
                end
            end
            if (!found) break;
            if (PKT) begin
                for (int k = 0; k < pend_len[r][0]; k++) tid_q.push_back(r);
                void'(pend_len[r].pop_front());
            end else begin
                tid_q.push_back(r);
                pend_len[r][0] = pend_len[r][0] - 1;
                if (pend_len[r][0] == 0) void'(pend_len[r].pop_front());
            end
            model_last = r;
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int r = 0; r < N; r++) n += exp_q[r].size();
        return n;
    endfunction

    task automatic check_out();
        int t;
        beat_t e;
        t = int'(as_is_tid);
        chk("tid_range", 64'(t < N), 64'(1));
        if (tid_q.size() > 0) chk("tid_order", 64'(as_is_tid), 64'(tid_q.pop_front()));
        if (t < N) begin
            chk("beat_expected", 64'(exp_q[t].size() > 0), 64'(1));
            if (exp_q[t].size() > 0) begin
                e = exp_q[t].pop_front();
                chk("beat", 64'({as_is_tdata, as_is_tstrb, as_is_tkeep, as_is_tuser, as_is_tlast}), 64'(e));
            end
        end
        if (timing_en) begin
            if (first_pending) begin
                chk("first_latency", 64'(cyc), 64'(first_exp));
                first_pending = 1'b0;
            end else begin
                chk("beat_gap", 64'(cyc - last_out_cyc), 64'((PKT && !prev_out_last) ? 1 : 2));
            end
        end
        last_out_cyc = cyc;
        prev_out_last = as_is_tlast;
    endtask

    task automatic step();
        logic [N-1:0] hs;
        @(negedge axis_clk);
        arb_en = arb_en_cmd;
        case (ready_mode)
            0: is_as_tready = 1'b1;
            1: is_as_tready = ($urandom_range(0, 9) < 6);
            default: is_as_tready = (cyc % 3 == 0);
        endcase
        for (int r = 0; r < N; r++) begin
            if (drv_q[r].size() > 0) begin
                s_tvalid[r] = 1'b1;
                s_tdata[r*W +: W] = drv_q[r][0].data;
                s_tstrb[r*S +: S] = drv_q[r][0].strb;
                s_tkeep[r*S +: S] = drv_q[r][0].keep;
                s_tuser[r*2 +: 2] = drv_q[r][0].user;
                s_tlast[r] = drv_q[r][0].last;
            end else begin
                s_tvalid[r] = 1'b0;
                s_tlast[r] = 1'b0;
            end
        end
        #1;
        hs = s_tvalid & s_tready;
        if (stall_prev) chk("hold", 64'({as_is_tvalid, as_is_tdata, as_is_tid, as_is_tlast}), held);
        stall_prev = as_is_tvalid && !is_as_tready;
        held = 64'({as_is_tvalid, as_is_tdata, as_is_tid, as_is_tlast});
        if (as_is_tvalid && is_as_tready) check_out();
        @(posedge axis_clk);
        for (int r = 0; r < N; r++) begin
            if (hs[r]) begin
                void'(drv_q[r].pop_front());
                hs_cnt[r]++;
            end
        end
        cyc++;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (pending() > 0 && n < bound) begin
            step();
            n++;
        end
        chk("drain_left", 64'(pending()), 64'(0));
        chk("order_left", 64'(tid_q.size()), 64'(0));
        repeat (3) step();
    endtask

    function automatic logic [63:0] outs_now();
        return 64'({as_is_tvalid, as_is_tdata, as_is_tstrb, as_is_tkeep, as_is_tid,
                    as_is_tuser, as_is_tlast, grant_vld, grant_id, s_tready});
    endfunction

    initial begin
        int n;
        model_last = N - 1;
        for (int r = 0; r < N; r++) hs_cnt[r] = 0;
        repeat (3) @(negedge axis_clk);
        #1;
        chk("reset_outputs", outs_now(), 64'(0));
        @(negedge axis_clk);
        axis_rst = 1'b0;
        arb_en_cmd = 1'b1;

        // All three requesters with 2-beat packets, ready held high
        ready_mode = 0;
        for (int r = 0; r < N; r++) add_pkt(r, 2, 32'h0, 1'b1);
        plan();
        timing_en = 1'b1;
        first_pending = 1'b1;
        first_exp = cyc + 2;
        drain(100);
        timing_en = 1'b0;

        // Requester 1 under a 1,0,0 ready pattern
        ready_mode = 2;
        add_pkt(1, 4, 32'h11110000, 1'b0);
        plan();
        drain(100);

        // Random packets with random backpressure
        ready_mode = 1;
        for (int round = 0; round < 6; round++) begin
            for (int p = 0; p < 2; p++)
                for (int r = 0; r < N; r++)
                    if ($urandom_range(0, 3) != 0) add_pkt(r, $urandom_range(1, 4), 32'h0, 1'b1);
            plan();
            drain(400);
        end

        // Grant enable dropped mid-packet of requester 2
        ready_mode = 0;
        for (int r = 0; r < N; r++) hs_cnt[r] = 0;
        add_pkt(2, 4, 32'h0, 1'b1);
        pend_len[2].delete();
        n = 0;
        while (hs_cnt[2] < 2 && n < 20) begin
            step();
            n++;
        end
        chk("arb_off_start", 64'(hs_cnt[2]), 64'(2));
        arb_en_cmd = 1'b0;
        add_pkt(0, 1, 32'h0, 1'b1);
        pend_len[0].delete();
        hs_cnt[0] = 0;
        hs_cnt[2] = 0;
        repeat (10) step();
        chk("arb_off_req2_beats", 64'(hs_cnt[2]), 64'(PKT ? 2 : 0));
        chk("arb_off_req0_blocked", 64'(hs_cnt[0]), 64'(0));
        @(negedge axis_clk);
        #1;
        chk("arb_off_grant", 64'(grant_vld), 64'(0));
        model_last = 2;
        pend_len[0].push_back(1);
        if (!PKT) pend_len[2].push_back(2);
        plan();
        arb_en_cmd = 1'b1;
        drain(100);

        // Reset pulsed during beat 3 of a 5-beat packet
        for (int r = 0; r < N; r++) hs_cnt[r] = 0;
        add_pkt(1, 5, 32'h0, 1'b1);
        pend_len[1].delete();
        n = 0;
        while (hs_cnt[1] < 3 && n < 30) begin
            step();
            n++;
        end
        chk("rst_mid_start", 64'(hs_cnt[1]), 64'(3));
        @(negedge axis_clk);
        axis_rst = 1'b1;
        #1;
        chk("rst_mid_outputs", outs_now(), 64'(0));
        for (int r = 0; r < N; r++) begin
            drv_q[r].delete();
            exp_q[r].delete();
            pend_len[r].delete();
        end
        tid_q.delete();
        stall_prev = 1'b0;
        s_tvalid = '0;
        @(negedge axis_clk);
        axis_rst = 1'b0;
        model_last = N - 1;
        add_pkt(0, 2, 32'h0, 1'b1);
        add_pkt(2, 2, 32'h0, 1'b1);
        plan();
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fsic_io_serdes_tx_arb.md
# fsic_io_serdes_tx_arb

Packet-level round-robin arbiter that shares the single IO serdes TX stream among up to four upstream AXI-Stream requesters. Sits in the `axis_clk` domain directly in front of the serdes `as_is_*` input. Each beat is tagged with its requester index on `as_is_tid`. Remote-side backpressure (`is_as_tready`) is honoured through a one-entry registered output stage.

## Interface
Parameters:
- `pN_REQ`, 3: number of requesters (1..4).
- `pDATA_WIDTH`, 32: tdata width; tstrb/tkeep are `pDATA_WIDTH/8`.

Ports:
- `axis_clk` in 1: the only clock.
- `axis_rst` in 1: reset, asynchronous and active-high.
- `arb_en` in 1: grant enable; low blocks new grants.
- `s_tdata` in `pN_REQ*pDATA_WIDTH`: requester data, requester k at slice k.
- `s_tstrb`, `s_tkeep` in `pN_REQ*pDATA_WIDTH/8`: per-requester strobes.
- `s_tuser` in `2*pN_REQ`: per-requester tuser.
- `s_tlast` in `pN_REQ`: per-requester tlast.
- `s_tvalid` in `pN_REQ`: per-requester tvalid.
- `s_tready` out `pN_REQ`: per-requester tready.
- `as_is_tdata` out `pDATA_WIDTH`: to serdes.
- `as_is_tstrb`, `as_is_tkeep` out `pDATA_WIDTH/8`: to serdes.
- `as_is_tid` out 2: index of the requester that owns the beat.
- `as_is_tuser` out 2: to serdes.
- `as_is_tlast` out 1: to serdes.
- `as_is_tvalid` out 1: to serdes.
- `is_as_tready` in 1: serdes/remote ready.
- `grant_vld` out 1: a requester currently owns the link.
- `grant_id` out 2: current owner index.

## Operation
- Output stage:
  - Beat transfer on the output side occurs when `as_is_tvalid && is_as_tready`.
  - `load = !as_is_tvalid || is_as_tready`.
- State machine with two states:
  - IDLE:
    - If `arb_en` and any `s_tvalid` is high, select the first requester with valid, searching from `last+1` mod `pN_REQ`.
    - Set `owner`, set `last=owner`, go to LOCKED. The grant takes effect the next cycle.
  - LOCKED(owner):
    - `s_tready[owner] = load`. All other `s_tready` are 0.
    - On an accepted beat (`s_tvalid[owner] && load`), register the beat into the output stage and set `as_is_tid=owner`.
    - An accepted beat with `s_tlast` returns the FSM to IDLE.
- Idle output stage: when `load` is high and no beat is accepted, `as_is_tvalid` drops to 0.
- `arb_en` deasserted while LOCKED: the current packet completes through tlast. Only new grants are blocked.
- Requesters with index ≥ `pN_REQ` do not exist. `s_tready` is 0 in IDLE.
- Upstream rules: a requester's `s_tvalid` may not drop before its handshake. Data, strobes, user and last are sampled only on an accepted beat.
- `grant_vld` is 1 in LOCKED, else 0. `grant_id = owner`.

## Timing
- Reset values:
  - All outputs are 0.
  - `owner=0`.
  - `last=pN_REQ-1`, so requester 0 wins the first arbitration.
  - FSM is in IDLE.
- Arbitration latency: `s_tvalid` rising in IDLE gives the grant in cycle +1. The first `s_tready` is possible in cycle +1, and `as_is_tvalid` in cycle +2.
- Steady-state throughput is 1 beat/cycle while `is_as_tready=1`.
- Packet boundary: one IDLE bubble cycle follows each tlast beat, so back-to-back packets from different requesters have a 1-cycle gap.
- Backpressure: with `is_as_tready=0` and `as_is_tvalid=1`, the output holds stable and `s_tready[owner]=0`. The beat is delivered in the first cycle `is_as_tready=1`, and a new beat may load in that same cycle.
- Simultaneous events:
  - All requesters valid in IDLE: strict rotation, one packet each in the order `last+1`, `last+2`, ….
  - tlast accepted in the same cycle as `arb_en` falls: return to IDLE with no new grant.
- Reset asserted mid-packet: immediate return to reset values. The partial beat in the output stage is discarded, and the remote sees `as_is_tvalid=0`.
- Single-beat packet (tlast on the first beat): LOCKED lasts exactly one accepting cycle.

## Configuration
- `FSIC_TX_ARB_PKT_LOCK_EN` defined: behaviour as above, with the grant held until tlast.
- `FSIC_TX_ARB_PKT_LOCK_EN` undefined:
  - The FSM returns to IDLE after every accepted beat, giving beat-level round-robin with a 1-cycle bubble per beat.
  - `s_tlast` is passed through but ignored for arbitration.
  - Intended for non-packet (single-beat) traffic.

## Test plan
- Reset, then `s_tvalid=3'b111`, each requester sending a 2-beat packet, `is_as_tready=1`:
  - `as_is_tid` sequence is 0,0,1,1,2,2.
  - There is a 1-cycle `as_is_tvalid=0` gap between packets.
- Requester 1 sends 4 beats (`32'h11110000`…`32'h11110003`) and `is_as_tready` toggles 1,0,0,1,…:
  - The output beats appear in order, with no drop or duplicate.
  - `as_is_tdata` stays stable while ready is 0.
- Requester 2 is mid-packet (beat 2 of 4) and `arb_en` goes 0:
  - The remaining 2 beats complete.
  - `grant_vld` falls after tlast.
  - No new grant occurs while requester 0 is valid until `arb_en=1`.
- `axis_rst` is pulsed during beat 3 of a 5-beat packet:
  - All outputs are 0 immediately.
  - After release with requesters 0 and 2 valid, requester 0 is granted first.
- Macro undefined, requesters 0 and 1 each sending 3-beat packets:
  - `as_is_tid` interleaves 0,1,0,1,0,1.
  - tlast is preserved per beat.
- `pN_REQ=1`, a continuous 8-beat packet with `is_as_tready=1`:
  - The beats arrive at 1 beat/cycle after 2-cycle initial latency.
  - `as_is_tid=0` throughout.
